mem_stage_ctrl: RTL and testbench

Memory-stage controller that sits directly upstream of the byte-addressed data memory and drives its access port. It turns scalar RV32 load/store requests into single memory accesses with byte/half/word select and load sign/zero extension. It also sequences matrix load/store instructions as multi-beat word bursts between the data memory and the matrix register file, stalling the pipeline for the burst duration.

---
 rtl/mem_stage_if.sv | 48 ++++
 rtl/mem_stage_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Memory-stage bundle: pipeline request, data-memory port, matrix
// register-file port and the status/result signals back to the pipeline.
interface mem_stage_if #(
  parameter int MAT_WORDS = 16,
  parameter int IDX_W     = $clog2(MAT_WORDS)
);
  logic             req_valid;
  logic             req_load;
  logic             req_matrix;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;

  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_r_en;
  logic             mem_w_en;
  logic [1:0]       mem_byte_sel;
  logic             mem_mat;
  logic [31:0]      mem_rdata;

  logic [IDX_W-1:0] mat_idx;
  logic [31:0]      mat_rdata;
  logic             mat_we;
  logic [31:0]      mat_wdata;

  logic             stall;
  logic [31:0]      load_data;
  logic             load_valid;
  logic             mem_fault;
  logic             done;

  modport master (
    input  req_valid, req_load, req_matrix, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mat_rdata,
    output mem_addr, mem_wdata, mem_r_en, mem_w_en, mem_byte_sel, mem_mat,
    output mat_idx, mat_we, mat_wdata,
    output stall, load_data, load_valid, mem_fault, done
  );

  modport slave (
    output req_valid, req_load, req_matrix, req_funct3, req_addr, req_wdata,
    output mem_rdata, mat_rdata,
    input  mem_addr, mem_wdata, mem_r_en, mem_w_en, mem_byte_sel, mem_mat,
    input  mat_idx, mat_we, mat_wdata,
    input  stall, load_data, load_valid, mem_fault, done
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: single-cycle scalar loads/stores with size select
// and load extension, plus multi-beat word bursts between data memory and the
// matrix register file for matrix load/store instructions.
//
// state | meaning
// IDLE  | scalar accesses issued combinationally; matrix request accepted
// BURST | one word per cycle, beat k at base+4k, pipeline stalled
// DONE  | done pulse, no access, presented request ignored
module mem_stage_ctrl #(
  parameter int MAT_WORDS = 16,
  parameter int IDX_W     = $clog2(MAT_WORDS)
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(MAT_WORDS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] beat, beat_nxt;
  logic [31:0]      base, base_nxt;
  logic             dir_load, dir_load_nxt;
  logic             fault;
  logic             load_go;
  logic             fault_go;
  logic [31:0]      load_ext;

  // Request legality: unsupported funct3 encodings and misaligned addresses.
  always_comb begin
    fault = 1'b0;
    if (bus.req_matrix) begin
      fault = (bus.req_addr[1:0] != 2'b00);
    end else begin
      if (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11) fault = 1'b1;
      if (!bus.req_load && bus.req_funct3[2]) fault = 1'b1;
      if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) fault = 1'b1;
      if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) fault = 1'b1;
    end
  end

  // Load result shaping: the addressed byte/half sits in the low lanes of mem_rdata.
  always_comb begin
    case (bus.req_funct3)
      3'b000:  load_ext = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      3'b001:  load_ext = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      3'b100:  load_ext = {24'h0, bus.mem_rdata[7:0]};
      3'b101:  load_ext = {16'h0, bus.mem_rdata[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // Next-state and access outputs; everything forced idle while reset is high.
  always_comb begin
    state_nxt        = state;
    beat_nxt         = beat;
    base_nxt         = base;
    dir_load_nxt     = dir_load;
    load_go          = 1'b0;
    fault_go         = 1'b0;
    bus.mem_addr     = 32'h0;
    bus.mem_wdata    = 32'h0;
    bus.mem_r_en     = 1'b0;
    bus.mem_w_en     = 1'b0;
    bus.mem_byte_sel = 2'b00;
    bus.mem_mat      = 1'b0;
    bus.mat_idx      = '0;
    bus.mat_we       = 1'b0;
    bus.mat_wdata    = 32'h0;
    bus.stall        = 1'b0;
    bus.done         = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (fault) begin
              fault_go = 1'b1;
            end else if (bus.req_matrix) begin
              bus.stall    = 1'b1;
              base_nxt     = bus.req_addr;
              dir_load_nxt = bus.req_load;
              beat_nxt     = '0;
              state_nxt    = BURST;
            end else begin
              bus.mem_addr     = bus.req_addr;
              bus.mem_byte_sel = bus.req_funct3[1:0];
              if (bus.req_load) begin
                bus.mem_r_en = 1'b1;
                load_go      = 1'b1;
              end else begin
                bus.mem_w_en  = 1'b1;
                bus.mem_wdata = bus.req_wdata;
              end
            end
          end
        end
        BURST: begin
          bus.mem_addr     = base + 32'({beat, 2'b00});
          bus.mem_byte_sel = 2'b10;
          bus.mem_mat      = 1'b1;
          bus.mat_idx      = beat;
          bus.stall        = 1'b1;
          if (dir_load) begin
            bus.mem_r_en  = 1'b1;
            bus.mat_we    = 1'b1;
            bus.mat_wdata = bus.mem_rdata;
          end else begin
            bus.mem_w_en  = 1'b1;
            bus.mem_wdata = bus.mat_rdata;
          end
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = DONE;
          end else begin
            beat_nxt = beat + IDX_W'(1);
          end
        end
        DONE: begin
          bus.done  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, burst context and registered load/fault results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      beat           <= '0;
      base           <= 32'h0;
      dir_load       <= 1'b0;
      bus.load_data  <= 32'h0;
      bus.load_valid <= 1'b0;
      bus.mem_fault  <= 1'b0;
    end else begin
      state          <= state_nxt;
      beat           <= beat_nxt;
      base           <= base_nxt;
      dir_load       <= dir_load_nxt;
      bus.load_valid <= load_go;
      bus.mem_fault  <= fault_go;
      if (load_go) bus.load_data <= load_ext;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: byte memory and matrix RF environment, a
// transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_mem_stage_ctrl;
  localparam int W     = 16;
  localparam int IDX_W = 4;

  logic clk;
  logic rst;

  mem_stage_if #(.MAT_WORDS(W), .IDX_W(IDX_W)) ifc ();

  mem_stage_ctrl #(.MAT_WORDS(W), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // environment: 1 KiB byte memory (address aliased) and the matrix RF
  logic [7:0]  env_mem [1024];
  logic [31:0] env_rf  [W];
  // reference copies maintained purely by the model
  logic [7:0]  ref_mem [1024];
  logic [31:0] ref_rf  [W];

  always_comb begin
    ifc.mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++)
      ifc.mem_rdata[8*i +: 8] = env_mem[10'(ifc.mem_addr + 32'(i))];
  end
  assign ifc.mat_rdata = env_rf[ifc.mat_idx];

  int n_checks;
  int n_fail;

  // model state: m_off = cycles since matrix accept, -1 when not in a matrix op
  int          m_off;
  logic [31:0] m_base;
  logic        m_load;
  logic        exp_lv;
  logic        exp_fault;
  logic [31:0] exp_ld;

  logic [2:0]  lf3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [31:0] la   [5] = '{32'h10, 32'h10, 32'h10, 32'h12, 32'h10};
  logic [31:0] lexp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F80,
                            32'h0000_01FF, 32'h01FF_7F80};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[10'(a + 32'(i))];
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int nb);
    for (int i = 0; i < nb; i++) ref_mem[10'(a + 32'(i))] = d[8*i +: 8];
  endtask

  function automatic logic is_fault(input logic ld, input logic mat,
                                    input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (mat) return (a % 4) != 0;
    if (ld) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    end else begin
      if (f3 > 3'd2) return 1'b1;
    end
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'd0:    return (w[7:0]  >= 8'h80)    ? (w[7:0]  | 32'hFFFF_FF00) : {24'h0, w[7:0]};
      3'd1:    return (w[15:0] >= 16'h8000) ? (w[15:0] | 32'hFFFF_0000) : {16'h0, w[15:0]};
      3'd4:    return {24'h0, w[7:0]};
      3'd5:    return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // One cycle of the reference model, compared against the DUT at negedge.
  task automatic check_cycle();
    logic [31:0] e_addr, e_wdata, e_mwdata, n_ld;
    logic        e_r, e_w, e_mat, e_we, e_stall, e_done, n_lv, n_fault;
    logic [1:0]  e_sel;
    logic [3:0]  e_idx;
    int          next_off, k;
    logic [141:0] act, exp;
    e_addr = 0; e_wdata = 0; e_mwdata = 0; e_r = 0; e_w = 0; e_mat = 0;
    e_we = 0; e_stall = 0; e_done = 0; e_sel = 0; e_idx = 0;
    n_lv = 0; n_fault = 0; n_ld = exp_ld; next_off = -1;
    if (rst) begin
      exp_lv = 0; exp_ld = 0; exp_fault = 0; n_ld = 0;
    end else if (m_off == -1) begin
      if (ifc.req_valid) begin
        if (is_fault(ifc.req_load, ifc.req_matrix, ifc.req_funct3, ifc.req_addr)) begin
          n_fault = 1;
        end else if (ifc.req_matrix) begin
          e_stall = 1; m_base = ifc.req_addr; m_load = ifc.req_load; next_off = 1;
        end else begin
          e_addr = ifc.req_addr;
          e_sel  = ifc.req_funct3[1:0];
          if (ifc.req_load) begin
            e_r = 1; n_lv = 1; n_ld = extend(ref_word(ifc.req_addr), ifc.req_funct3);
          end else begin
            e_w = 1; e_wdata = ifc.req_wdata;
            ref_store(ifc.req_addr, ifc.req_wdata, 1 << ifc.req_funct3[1:0]);
          end
        end
      end
    end else if (m_off <= W) begin
      k = m_off - 1;
      e_addr = m_base + 32'(4 * k);
      e_sel = 2'b10; e_mat = 1; e_idx = 4'(k); e_stall = 1;
      if (m_load) begin
        e_r = 1; e_we = 1; e_mwdata = ref_word(e_addr); ref_rf[k] = e_mwdata;
      end else begin
        e_w = 1; e_wdata = ref_rf[k]; ref_store(e_addr, ref_rf[k], 4);
      end
      next_off = m_off + 1;
    end else begin
      e_done = 1;
    end
    act = {ifc.mem_addr, ifc.mem_wdata, ifc.mem_r_en, ifc.mem_w_en, ifc.mem_byte_sel,
           ifc.mem_mat, ifc.mat_idx, ifc.mat_we, ifc.mat_wdata, ifc.stall, ifc.done,
           ifc.load_data, ifc.load_valid, ifc.mem_fault};
    exp = {e_addr, e_wdata, e_r, e_w, e_sel, e_mat, e_idx, e_we, e_mwdata, e_stall,
           e_done, exp_ld, exp_lv, exp_fault};
    chk("cycle_outputs", 160'(act), 160'(exp));
    exp_lv = n_lv; exp_ld = n_ld; exp_fault = n_fault; m_off = next_off;
  endtask

  // Check at negedge, then commit environment writes at the following edge.
  task automatic tick();
    logic        cw, rw;
    logic [31:0] ca, cd, rd;
    int          cnb;
    logic [3:0]  ri;
    @(negedge clk);
    check_cycle();
    cw = ifc.mem_w_en; ca = ifc.mem_addr; cd = ifc.mem_wdata;
    cnb = ifc.mem_mat ? 4 : (1 << ifc.mem_byte_sel);
    rw = ifc.mat_we; ri = ifc.mat_idx; rd = ifc.mat_wdata;
    @(posedge clk);
    if (cw) for (int i = 0; i < cnb; i++) env_mem[10'(ca + 32'(i))] = cd[8*i +: 8];
    if (rw) env_rf[ri] = rd;
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic mat,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    ifc.req_valid = v; ifc.req_load = ld; ifc.req_matrix = mat;
    ifc.req_funct3 = f3; ifc.req_addr = a; ifc.req_wdata = d;
  endtask

  initial begin
    int nst, dat, good, nd;
    logic [63:0] win;
    logic [2:0]  f3;
    logic [31:0] a;
    n_checks = 0; n_fail = 0;
    m_off = -1; m_base = 0; m_load = 0; exp_lv = 0; exp_ld = 0; exp_fault = 0;
    for (int i = 0; i < 1024; i++) env_mem[i] = 8'(i * 37 + 5);
    env_mem[16] = 8'h80; env_mem[17] = 8'h7F; env_mem[18] = 8'hFF; env_mem[19] = 8'h01;
    for (int i = 32; i < 40; i++) env_mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) ref_mem[i] = env_mem[i];
    for (int k = 0; k < W; k++) begin env_rf[k] = 32'(k + 1); ref_rf[k] = 32'(k + 1); end

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // scalar loads from bytes 80 7F FF 01 at 0x10
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, lf3[i], la[i], 0);
      tick();
      chk("scalar_load", 160'({ifc.load_valid, ifc.load_data}), 160'({1'b1, lexp[i]}));
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // scalar stores SB/SH/SW
    drive(1, 0, 0, 3'b000, 32'h21, 32'hAABB_CCDD); tick();
    drive(1, 0, 0, 3'b001, 32'h22, 32'hAABB_CCDD); tick();
    drive(1, 0, 0, 3'b010, 32'h24, 32'hAABB_CCDD); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 8; i++) win[8*i +: 8] = env_mem[32 + i];
    chk("scalar_store_bytes", 160'(win), 160'(64'hAABB_CCDD_CCDD_DD00));

    // faults
    drive(1, 1, 0, 3'b010, 32'h13, 0); tick();
    chk("fault_lw", 160'({ifc.mem_fault, ifc.load_valid}), 160'(2'b10));
    drive(1, 1, 0, 3'b001, 32'h11, 0); tick();
    chk("fault_lh", 160'({ifc.mem_fault, ifc.load_valid}), 160'(2'b10));
    drive(1, 1, 0, 3'b011, 32'h10, 0); tick();
    chk("fault_f3", 160'({ifc.mem_fault, ifc.load_valid}), 160'(2'b10));
    drive(0, 0, 0, 0, 0, 0); tick();

    // matrix store at 0x100, RF word k = k+1
    drive(1, 0, 1, 3'b010, 32'h100, 0);
    nst = 0; dat = 0;
    for (int c = 1; c <= 30 && dat == 0; c++) begin
      #1;
      if (ifc.stall) nst++;
      if (ifc.done) dat = c;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("mat_st_stall_cycles", 160'(nst), 160'(17));
    chk("mat_st_done_cycle", 160'(dat), 160'(18));
    good = 0;
    for (int k = 0; k < W; k++)
      if ({env_mem[259 + 4*k], env_mem[258 + 4*k], env_mem[257 + 4*k], env_mem[256 + 4*k]}
          == 32'(k + 1)) good++;
    chk("mat_st_mem_words", 160'(good), 160'(16));
    tick();

    // clear RF, then matrix load from the same base restores it
    for (int k = 0; k < W; k++) begin env_rf[k] = 0; ref_rf[k] = 0; end
    drive(1, 1, 1, 3'b010, 32'h100, 0);
    dat = 0;
    for (int c = 1; c <= 30 && dat == 0; c++) begin
      #1;
      if (ifc.done) dat = c;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("mat_ld_done_cycle", 160'(dat), 160'(18));
    good = 0;
    for (int k = 0; k < W; k++) if (env_rf[k] == 32'(k + 1)) good++;
    chk("mat_ld_rf_words", 160'(good), 160'(16));
    tick();

    // wrapping matrix load, reset during beat 5
    drive(1, 1, 1, 3'b010, 32'hFFFF_FFF8, 0);
    for (int c = 1; c <= 7; c++) begin
      #1;
      if (c == 3) chk("wrap_beat1_addr", 160'(ifc.mem_addr), 160'(32'hFFFF_FFFC));
      if (c == 4) chk("wrap_beat2_addr", 160'(ifc.mem_addr), 160'(32'h0000_0000));
      if (c == 7) begin
        rst = 1'b1;
        #1;
        chk("rst_outputs_zero", 160'({ifc.stall, ifc.mem_r_en, ifc.mat_we, ifc.mem_addr,
                                      ifc.mat_idx, ifc.done}), 160'(0));
      end
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ifc.done || ifc.stall) nd++;
      tick();
    end
    chk("no_done_after_rst", 160'(nd), 160'(0));

    // randomized traffic
    for (int it = 0; it < 1500; it++) begin
      if (m_off == -1) begin
        f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1 && f3[1:0] != 2'b11 && $urandom_range(0, 5) == 0)
          f3[2] = 1'b1;
        a = $urandom;
        if ($urandom_range(0, 9) < 8) a[1:0] = 2'b00;
        if ($urandom_range(0, 12) == 0)
          drive($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 1, 3'b010, a, $urandom);
        else
          drive($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 0, f3, a, $urandom);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20 && m_off != -1; c++) tick();
    tick();

    good = 0;
    for (int i = 0; i < 1024; i++) if (env_mem[i] == ref_mem[i]) good++;
    chk("final_mem_image", 160'(good), 160'(1024));
    good = 0;
    for (int k = 0; k < W; k++) if (env_rf[k] == ref_rf[k]) good++;
    chk("final_rf_image", 160'(good), 160'(W));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
